sub_bytes_engine: RTL and testbench



---
 rtl/sub_bytes_engine.sv | 121 ++++++++++++
 tb/tb_sub_bytes_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_engine.sv
// SubBytes over a 128-bit AES state using LANES S-boxes per cycle; latency 16/LANES cycles, one state in flight.
// Result holds in DONE until out_ready; macro SBOX_INV_EN compiles in the inverse table selected by in_inv.
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16 (got %0d)", LANES);
    end

    // Row r of the literal holds entries 16r..16r+15, leftmost byte first.
    localparam logic [0:255][7:0] FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SBOX_INV_EN
    localparam logic [0:255][7:0] INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    logic mode;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [15:0][7:0] work;
    logic [15:0][7:0] work_next;
    logic [CW-1:0]    cnt;
    logic [3:0]       base;

    assign in_ready = (state == IDLE);
    assign base     = 4'(int'(cnt) * LANES);

    // Only the current group of LANES bytes is replaced; the rest pass through.
    always_comb begin
        work_next = work;
        for (int l = 0; l < LANES; l++) begin
`ifdef SBOX_INV_EN
            work_next[base + 4'(l)] = mode ? INV_TBL[work[base + 4'(l)]] : FWD_TBL[work[base + 4'(l)]];
`else
            work_next[base + 4'(l)] = FWD_TBL[work[base + 4'(l)]];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
`ifdef SBOX_INV_EN
            mode      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_data;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef SBOX_INV_EN
                        mode  <= in_inv;
`endif
                    end
                end
                RUN: begin
                    work <= work_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        out_data  <= work_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: S-box reference derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_engine;
`ifdef SBOX_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic         sw_in_valid [4];
    logic         sw_in_ready [4];
    logic [127:0] sw_in_data;
    logic         sw_in_inv;
    logic         sw_out_valid [4];
    logic         sw_out_ready;
    logic [127:0] sw_out_data [4];
    logic         sw_busy [4];

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sub_bytes_engine #(.LANES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        sub_bytes_engine #(.LANES(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 8 : 16)) dut_sw (
            .clk(clk), .rst_n(rst_n),
            .in_valid(sw_in_valid[g]), .in_ready(sw_in_ready[g]), .in_data(sw_in_data), .in_inv(sw_in_inv),
            .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready), .out_data(sw_out_data[g]), .busy(sw_busy[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a ^= 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_model();
        logic [7:0] xi, s;
        for (int x = 0; x < 256; x++) begin
            xi = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
            s = xi ^ rotl(xi, 1) ^ rotl(xi, 2) ^ rotl(xi, 3) ^ rotl(xi, 4) ^ 8'h63;
            fwd_tbl[x] = s;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = (inv && INV_EN) ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drives one operation on the LANES=4 instance; returns the result and cycles from accept to out_valid.
    task automatic do_op(input logic [127:0] d, input logic inv, output logic [127:0] res, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_data;
    endtask

    task automatic test_reset();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    endtask

    task automatic test_forward();
        logic [127:0] res, d, want;
        int lat;
        want = 128'h637c777bf26b6fc53001672bfed7ab76;
        do_op(128'h000102030405060708090a0b0c0d0e0f, 1'b0, res, lat);
        n_checks++; if (res !== want) begin n_fail++; $display("FAIL fwd_vector: got %h want %h", res, want); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL fwd_latency: got %0d want 4", lat); end
        for (int r = 0; r < 6; r++) begin
            d = rand128();
            do_op(d, 1'b0, res, lat);
            n_checks++; if (res !== model(d, 1'b0)) begin n_fail++; $display("FAIL fwd_random: in %h got %h want %h", d, res, model(d, 1'b0)); end
            n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL fwd_random_latency: got %0d want 4", lat); end
        end
    endtask

    task automatic test_inverse();
        logic [127:0] res, d, w1, w2;
        logic inv;
        int lat;
        w1 = INV_EN ? {16{8'h00}} : {16{8'hfb}};
        w2 = INV_EN ? {16{8'h53}} : {16{8'h55}};
        do_op({16{8'h63}}, 1'b1, res, lat);
        n_checks++; if (res !== w1) begin n_fail++; $display("FAIL inv_all63: got %h want %h", res, w1); end
        do_op({16{8'hed}}, 1'b1, res, lat);
        n_checks++; if (res !== w2) begin n_fail++; $display("FAIL inv_allED: got %h want %h", res, w2); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL inv_latency: got %0d want 4", lat); end
        for (int r = 0; r < 6; r++) begin
            d   = rand128();
            inv = 1'($urandom_range(0, 1));
            do_op(d, inv, res, lat);
            n_checks++; if (res !== model(d, inv)) begin n_fail++; $display("FAIL mode_random: inv %b in %h got %h want %h", inv, d, res, model(d, inv)); end
        end
    endtask

    task automatic test_lane_sweep();
        logic [127:0] d, want;
        int lat, lanes;
        for (int k = 0; k < 4; k++) begin
            lanes = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 16;
            for (int r = 0; r < 3; r++) begin
                d    = (r == 0) ? {16{8'hff}} : rand128();
                want = (r == 0) ? {16{8'h16}} : model(d, 1'b0);
                @(negedge clk);
                n_checks++; if (sw_in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready: lanes %0d got %b want 1", lanes, sw_in_ready[k]); end
                sw_in_data     = d;
                sw_in_valid[k] = 1'b1;
                @(posedge clk);
                #1;
                sw_in_valid[k] = 1'b0;
                n_checks++; if (sw_busy[k] !== 1'b1) begin n_fail++; $display("FAIL sweep_busy: lanes %0d got %b want 1", lanes, sw_busy[k]); end
                lat = 0;
                while (!sw_out_valid[k] && lat < 40) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                n_checks++; if (lat !== 16 / lanes) begin n_fail++; $display("FAIL sweep_latency: lanes %0d got %0d want %0d", lanes, lat, 16 / lanes); end
                n_checks++; if (sw_out_data[k] !== want) begin n_fail++; $display("FAIL sweep_data: lanes %0d got %h want %h", lanes, sw_out_data[k], want); end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] res, d1, w1;
        int lat;
        d1 = rand128();
        w1 = model(d1, 1'b0);
        out_ready = 1'b0;
        do_op(d1, 1'b0, res, lat);
        n_checks++; if (res !== w1) begin n_fail++; $display("FAIL bp_result: got %h want %h", res, w1); end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = ~d1;
        in_inv   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: cycle %0d got %b want 1", c, out_valid); end
            n_checks++; if (out_data !== w1) begin n_fail++; $display("FAIL bp_out_data: cycle %0d got %h want %h", c, out_data, w1); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, in_ready); end
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== w1) begin n_fail++; $display("FAIL bp_release_out_data_kept: got %h want %h", out_data, w1); end
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_capture_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] res, d;
        int lat;
        bit saw_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rand128();
        in_inv   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_busy: got %b want 0", busy); end
        n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL midrun_out_data: got %h want 0", out_data); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_in_ready: got %b want 1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_aborted_valid: got %b want 0", saw_valid); end
        d = rand128();
        do_op(d, 1'b0, res, lat);
        n_checks++; if (res !== model(d, 1'b0)) begin n_fail++; $display("FAIL midrun_fresh_data: got %h want %h", res, model(d, 1'b0)); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL midrun_fresh_latency: got %0d want 4", lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_inv       = 1'b0;
        out_ready    = 1'b1;
        sw_in_data   = '0;
        sw_in_inv    = 1'b0;
        sw_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) sw_in_valid[k] = 1'b0;
        build_model();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_forward();
        test_inverse();
        test_lane_sweep();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
